load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 102 ++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store over a req/gnt/rvalid data-memory port.
// Define LSU_STORE_ACK_EN to make stores wait for dmem_rvalid as a write acknowledge.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic [3:0]        mem_write,
    input  logic [1:0]        read_size,
    input  logic              read_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state, state_nx;
    logic              is_st, is_sig, st_nx, legal, launch, tmo;
    logic [1:0]        sz, sz_nx;
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd, ld_ext;
    logic [7:0]        cnt, b;
    logic [15:0]       h;
    // Stores and loads share one size code; 3 marks an illegal mask or read_size.
    always_comb begin
        st_nx  = |mem_write;
        sz_nx  = st_nx ? (mem_write == 4'b0001 ? 2'd0 : mem_write == 4'b0011 ? 2'd1 :
                          mem_write == 4'b1111 ? 2'd2 : 2'd3) : read_size;
        legal  = sz_nx != 2'd3 && !(sz_nx == 2'd1 && addr[0]) && !(sz_nx == 2'd2 && addr[1:0] != 2'b00);
        launch = state == IDLE && start && (st_nx || mem_read);
        tmo    = (state == REQ || state == RESP) && cnt == 8'(TIMEOUT - 1);
        b      = 8'(dmem_rdata >> {a[1:0], 3'b000});
        h      = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_ext = sz == 2'd0 ? {{24{is_sig & b[7]}}, b} :
                 sz == 2'd1 ? {{16{is_sig & h[15]}}, h} : dmem_rdata;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (launch) state_nx = legal ? REQ : DONE;
`ifdef LSU_STORE_ACK_EN
            REQ:  state_nx = tmo ? DONE : dmem_gnt ? RESP : REQ;
`else
            REQ:  state_nx = tmo ? DONE : dmem_gnt ? (is_st ? DONE : RESP) : REQ;
`endif
            RESP: state_nx = (tmo || dmem_rvalid) ? DONE : RESP;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            is_st  <= 1'b0;
            is_sig <= 1'b0;
            sz     <= 2'd0;
            a      <= '0;
            wd     <= '0;
            cnt    <= '0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (launch) begin
                is_st  <= st_nx;
                is_sig <= read_signed;
                sz     <= sz_nx;
                a      <= addr;
                wd     <= wdata;
            end
            cnt <= launch ? 8'd0 : busy ? cnt + 8'd1 : cnt;
            // Entering DONE straight from IDLE means the op failed its legality check.
            if (state_nx == DONE) err <= state == IDLE || tmo;
            if (state == RESP && dmem_rvalid && !tmo && !is_st) rdata <= ld_ext;
        end
    end
    always_comb begin
        busy       = state == REQ || state == RESP;
        done       = state == DONE;
        dmem_req   = state == REQ;
        dmem_we    = dmem_req && is_st;
        dmem_be    = !dmem_req ? 4'b0000 :
                     !is_st ? 4'b1111 :
                     (sz == 2'd0 ? 4'b0001 : sz == 2'd1 ? 4'b0011 : 4'b1111) << a[1:0];
        dmem_addr  = dmem_req ? {a[ADDR_W-1:2], 2'b00} : '0;
        dmem_wdata = !dmem_we ? 32'd0 :
                     sz == 2'd0 ? {4{wd[7:0]}} : sz == 2'd1 ? {2{wd[15:0]}} : wd;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit, plus a TIMEOUT=4 instance for abort and reset cases.
module tb_load_store_unit;
`ifdef LSU_STORE_ACK_EN
    localparam int ST_LAT = 3;
`else
    localparam int ST_LAT = 2;
`endif
    logic        clk = 0, rst_n = 0, start = 0, mem_read = 0, read_signed = 0;
    logic        dmem_gnt = 0, dmem_rvalid = 0;
    logic [3:0]  mem_write = 0;
    logic [1:0]  read_size = 0;
    logic [31:0] addr = 0, wdata = 0, dmem_rdata = 0;
    logic        busy, done, err, dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] rdata, dmem_addr, dmem_wdata;
    logic        busy_t, done_t, err_t, dmem_req_t, dmem_we_t;
    logic [3:0]  dmem_be_t;
    logic [31:0] rdata_t, dmem_addr_t, dmem_wdata_t;
    int n_checks = 0, n_fail = 0, cyc = 0, t0 = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .read_size(read_size), .read_signed(read_signed), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata));

    load_store_unit #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .read_size(read_size), .read_signed(read_signed), .addr(addr), .wdata(wdata),
        .busy(busy_t), .done(done_t), .rdata(rdata_t), .err(err_t), .dmem_req(dmem_req_t), .dmem_we(dmem_we_t),
        .dmem_be(dmem_be_t), .dmem_addr(dmem_addr_t), .dmem_wdata(dmem_wdata_t),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic rd, input logic [3:0] wm, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        mem_read = rd; mem_write = wm; read_size = sz; read_signed = sg; addr = a; wdata = wd;
        start = 1; t0 = cyc;
        tick;
        start = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick; tick;
        n_checks++;
        if ({done, busy, err, dmem_req, dmem_we, dmem_be, rdata, dmem_addr, dmem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b busy=%b err=%b req=%b we=%b be=%h rdata=%h, required all 0",
                     done, busy, err, dmem_req, dmem_we, dmem_be, rdata);
        end
        rst_n = 1;
        tick;
    endtask

    task automatic test_lb;
        int lat;
        dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h80FF_1234;
        launch(1, 4'b0000, 2'd0, 1, 32'h103, 0);
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            n_fail++;
            $display("FAIL lb_req: got req=%b we=%b be=%h addr=%h, required 1 0 f 00000100", dmem_req, dmem_we, dmem_be, dmem_addr);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d required 3", lat); end
        n_checks++;
        if ({rdata, err} !== {32'hFFFF_FF80, 1'b0}) begin
            n_fail++;
            $display("FAIL lb_result: got rdata=%h err=%b, required ffffff80 0", rdata, err);
        end
    endtask

    task automatic test_lh;
        int lat;
        dmem_rdata = 32'hBEEF_0000;
        launch(1, 4'b0000, 2'd1, 0, 32'h102, 0);
        wait_done(lat);
        n_checks++;
        if ({rdata, err, lat} !== {32'h0000_BEEF, 1'b0, 32'd3}) begin
            n_fail++;
            $display("FAIL lhu_result: got rdata=%h err=%b lat=%0d, required 0000beef 0 3", rdata, err, lat);
        end
        launch(1, 4'b0000, 2'd1, 1, 32'h102, 0);
        wait_done(lat);
        n_checks++;
        if ({rdata, err} !== {32'hFFFF_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL lh_result: got rdata=%h err=%b, required ffffbeef 0", rdata, err);
        end
    endtask

    task automatic test_store;
        int lat;
        launch(1, 4'b0001, 2'd0, 0, 32'h201, 32'h1234_56AB);
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 4'b0010, 32'h200, 32'hABAB_ABAB}) begin
            n_fail++;
            $display("FAIL sb_req: got req=%b we=%b be=%b addr=%h wdata=%h, required 1 1 0010 00000200 abababab",
                     dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== ST_LAT) begin n_fail++; $display("FAIL sb_latency: got %0d required %0d", lat, ST_LAT); end
        n_checks++;
        if ({rdata, err} !== {32'hFFFF_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL sb_keeps_rdata: got rdata=%h err=%b, required ffffbeef 0", rdata, err);
        end
        launch(0, 4'b0011, 2'd0, 0, 32'h202, 32'h0000_CAFE);
        n_checks++;
        if ({dmem_be, dmem_wdata} !== {4'b1100, 32'hCAFE_CAFE}) begin
            n_fail++;
            $display("FAIL sh_lanes: got be=%b wdata=%h, required 1100 cafecafe", dmem_be, dmem_wdata);
        end
        wait_done(lat);
    endtask

    task automatic test_illegal;
        int lat;
        launch(0, 4'b1111, 2'd0, 0, 32'h202, 0);
        n_checks++;
        if ({dmem_req, done, err, rdata} !== {1'b0, 1'b1, 1'b1, 32'hFFFF_BEEF}) begin
            n_fail++;
            $display("FAIL sw_misaligned: got req=%b done=%b err=%b rdata=%h, required 0 1 1 ffffbeef", dmem_req, done, err, rdata);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL sw_misaligned_latency: got %0d required 1", lat); end
        launch(1, 4'b0000, 2'd1, 1, 32'h101, 0);
        n_checks++;
        if ({dmem_req, done, err} !== 3'b011) begin
            n_fail++;
            $display("FAIL lh_misaligned: got req=%b done=%b err=%b, required 0 1 1", dmem_req, done, err);
        end
        wait_done(lat);
        launch(1, 4'b0000, 2'd3, 0, 32'h100, 0);
        n_checks++;
        if ({dmem_req, done, err} !== 3'b011) begin
            n_fail++;
            $display("FAIL size3_illegal: got req=%b done=%b err=%b, required 0 1 1", dmem_req, done, err);
        end
        wait_done(lat);
        launch(0, 4'b0101, 2'd0, 0, 32'h100, 0);
        n_checks++;
        if ({dmem_req, done, err} !== 3'b011) begin
            n_fail++;
            $display("FAIL mask_illegal: got req=%b done=%b err=%b, required 0 1 1", dmem_req, done, err);
        end
        wait_done(lat);
        launch(0, 4'b0000, 2'd0, 0, 32'h100, 0);
        n_checks++;
        if ({busy, done, dmem_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL noop_start: got busy=%b done=%b req=%b, required 0 0 0", busy, done, dmem_req);
        end
        tick;
    endtask

    task automatic test_gnt_delay;
        int ndone = 0, lat = -1;
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h1122_3344;
        launch(1, 4'b0000, 2'd2, 0, 32'h300, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_gnt = 1;
            n_checks++;
            if ({dmem_req, busy, dmem_addr} !== {1'b1, 1'b1, 32'h300}) begin
                n_fail++;
                $display("FAIL gnt_delay_hold%0d: got req=%b busy=%b addr=%h, required 1 1 00000300", i, dmem_req, busy, dmem_addr);
            end
            ndone += int'(done);
            tick;
        end
        dmem_gnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) begin
                ndone++;
                if (lat < 0) lat = cyc - t0;
            end
            tick;
        end
        n_checks++;
        if ({ndone, lat} !== {32'd1, 32'd6}) begin
            n_fail++;
            $display("FAIL gnt_delay_done: got %0d pulses at cycle %0d, required 1 at cycle 6", ndone, lat);
        end
        n_checks++;
        if ({rdata, err} !== {32'h1122_3344, 1'b0}) begin
            n_fail++;
            $display("FAIL gnt_delay_result: got rdata=%h err=%b, required 11223344 0", rdata, err);
        end
    endtask

    task automatic test_timeout;
        dmem_gnt = 0; dmem_rvalid = 0;
        launch(1, 4'b0000, 2'd2, 0, 32'h400, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dmem_req_t !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_req%0d: got req=%b required 1", i, dmem_req_t);
            end
            tick;
        end
        n_checks++;
        if ({dmem_req_t, done_t, err_t} !== 3'b011) begin
            n_fail++;
            $display("FAIL timeout_abort: got req=%b done=%b err=%b, required 0 1 1", dmem_req_t, done_t, err_t);
        end
        tick;
        n_checks++;
        if ({done_t, busy_t} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_done_pulse: got done=%b busy=%b, required 0 0", done_t, busy_t);
        end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        launch(1, 4'b0000, 2'd2, 0, 32'h500, 0);
        tick;
        n_checks++;
        if (dmem_req_t !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: got req=%b required 1", dmem_req_t); end
        rst_n = 0;
        #1;
        n_checks++;
        if ({dmem_req_t, busy_t, dmem_req, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_drop: got req_t=%b busy_t=%b req=%b busy=%b, required 0 0 0 0", dmem_req_t, busy_t, dmem_req, busy);
        end
        dmem_gnt = 1; dmem_rvalid = 1;
        tick; tick;
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            ndone += int'(done_t) + int'(done);
            tick;
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d done pulses required 0", ndone); end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_lh;
        test_store;
        test_illegal;
        test_gnt_delay;
        test_timeout;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
